// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: status codes, segment patterns, blink phase.
package stopwatch_pkg;

   localparam logic [1:0] STATUS_IDLE    = 2'b00;
   localparam logic [1:0] STATUS_RUNNING = 2'b01;
   localparam logic [1:0] STATUS_PAUSED  = 2'b10;

   // Segment order {g,f,e,d,c,b,a}, active low.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   typedef enum logic {
      PhaseOff = 1'b0,
      PhaseOn  = 1'b1
   } blink_phase_e;

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      seg = SEG_BLANK;
      if (nib < 4'd10) seg = SEG_TABLE[nib];
      return seg;
   endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Time inputs from the counters and the multiplexed 7-segment outputs of the display stage.
interface stopwatch_display_if;

   logic [7:0] minutes;
   logic [5:0] seconds;
   logic [1:0] status;
   logic [6:0] seg_n;
   logic [3:0] an_n;
   logic       dp_n;

   modport master (
      output minutes, seconds, status,
      input  seg_n, an_n, dp_n
   );

   modport slave (
      input  minutes, seconds, status,
      output seg_n, an_n, dp_n
   );

endinterface

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Sequential 8-bit double-dabble: one shift-add-3 step per cycle, result and done after 8 steps.
module bin2bcd_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   // Upper 12 bits hold the BCD accumulator, lower 8 bits the binary being shifted out.
   logic [19:0] work_q;
   logic [19:0] work_shift;
   logic [11:0] acc_adj;
   logic [11:0] bcd_q;
   logic [2:0]  cnt_q;
   logic        busy_q;
   logic        done_q;

   always_comb begin
      acc_adj = work_q[19:8];
      for (int i = 0; i < 3; i++) begin
         if (work_q[8 + 4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = work_q[8 + 4*i +: 4] + 4'd3;
      end
      work_shift = {acc_adj, work_q[7:0]} << 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) begin
            work_q <= work_shift;
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               bcd_q  <= work_shift[19:8];
            end
         end else if (start) begin
            work_q <= {12'd0, bin};
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS driver for a 4-digit multiplexed common-anode display: scan, per-frame BCD conversion,
// out-of-range dashes and blinking while paused.
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 50000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input logic                clk,
   input logic                rst_n,
   stopwatch_display_if.slave bus
);

   localparam int unsigned CntW   = $clog2(REFRESH_DIV);
   localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CntW-1:0]   ScanLast  = CntW'(REFRESH_DIV - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);

   logic [CntW-1:0]   scan_q;
   logic [1:0]        digit_q;
   logic              pending_q;
   logic [3:0][3:0]   nib_q;
   logic              min_dash_q;
   logic              sec_dash_q;
   blink_phase_e      phase_q;
   logic [BlinkW-1:0] blink_cnt_q;
   logic [6:0]        seg_q;
   logic [3:0]        an_q;
   logic              dp_q;

   logic        frame_tick;
   logic        conv_start;
   logic        min_busy, sec_busy, min_done, sec_done;
   logic [11:0] min_bcd, sec_bcd;
   logic        paused;
   logic        disp_on;
   logic        cur_dash;
   logic [6:0]  cur_seg;

   assign frame_tick = (scan_q == ScanLast) && (digit_q == 2'd3);
   assign conv_start = (frame_tick || pending_q) && !min_busy && !sec_busy;
   assign paused     = (bus.status == STATUS_PAUSED);

   bin2bcd_seq u_min_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   (bus.minutes),
      .busy  (min_busy),
      .done  (min_done),
      .bcd   (min_bcd)
   );

   bin2bcd_seq u_sec_conv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (conv_start),
      .bin   ({2'b00, bus.seconds}),
      .busy  (sec_busy),
      .done  (sec_done),
      .bcd   (sec_bcd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q    <= '0;
         digit_q   <= '0;
         pending_q <= 1'b1;
      end else begin
         if (conv_start) pending_q <= 1'b0;
         if (scan_q == ScanLast) begin
            scan_q  <= '0;
            digit_q <= digit_q + 2'd1;
         end else begin
            scan_q <= scan_q + 1'b1;
         end
      end
   end

   // Both digit pairs and their range flags swap together so a frame never mixes old and new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_q      <= '0;
         min_dash_q <= 1'b0;
         sec_dash_q <= 1'b0;
      end else if (min_done && sec_done) begin
         nib_q      <= {min_bcd[7:4], min_bcd[3:0], sec_bcd[7:4], sec_bcd[3:0]};
         min_dash_q <= (min_bcd[11:8] != 4'd0);
         sec_dash_q <= (sec_bcd[11:8] != 4'd0) || (sec_bcd[7:4] > 4'd5);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q     <= PhaseOn;
         blink_cnt_q <= '0;
      end else if (!paused) begin
         phase_q     <= PhaseOn;
         blink_cnt_q <= '0;
      end else if (frame_tick) begin
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_q <= '0;
            phase_q     <= (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end
   end

   // Leaving PAUSED lights the display on the very next registered cycle.
   assign disp_on  = !paused || (phase_q == PhaseOn);
   assign cur_dash = digit_q[1] ? min_dash_q : sec_dash_q;
   assign cur_seg  = cur_dash ? SEG_DASH : seg_decode(nib_q[digit_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= SEG_BLANK;
         an_q  <= 4'hF;
         dp_q  <= 1'b1;
      end else if (disp_on) begin
         seg_q <= cur_seg;
         an_q  <= ~(4'b0001 << digit_q);
         dp_q  <= (digit_q != 2'd2);
      end else begin
         seg_q <= SEG_BLANK;
         an_q  <= 4'hF;
         dp_q  <= 1'b1;
      end
   end

   assign bus.seg_n = seg_q;
   assign bus.an_n  = an_q;
   assign bus.dp_n  = dp_q;

endmodule
